// File: rtl/pixel_buf_pkg.sv
// Shared types and sizing helpers for the pixel stream buffer.
// Optional build macro: PIXEL_STREAM_BUFFER_BYPASS_EN (fall-through mode).
package pixel_buf_pkg;

  localparam int PIXEL_W = 16;

  typedef logic [PIXEL_W-1:0] pixel_t;

  localparam int DEF_DEPTH = 4;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int CNT_W = cnt_w(DEF_DEPTH);

endpackage

// File: rtl/pixel_buf_mem.sv
// Pixel storage: DEPTH x DATA_W registers, sync write, async read.
// Optional build macro: PIXEL_STREAM_BUFFER_BYPASS_EN (not used here).
module pixel_buf_mem
  import pixel_buf_pkg::*;
#(
  parameter int DATA_W = PIXEL_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pixel_stream_buffer.sv
// Handshaked pixel FIFO between DLX pixel fetch and the sharpening filter.
// Optional build macro: PIXEL_STREAM_BUFFER_BYPASS_EN (fall-through when empty).
module pixel_stream_buffer
  import pixel_buf_pkg::*;
#(
  parameter int DATA_W    = PIXEL_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_LVL = DEPTH - 1
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic [DATA_W-1:0]         IN_D,
  input  logic                      IN_VALID,
  output logic                      IN_READY,
  output logic [DATA_W-1:0]         OUT_D,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  input  logic                      FLUSH,
  output logic [cnt_w(DEPTH)-1:0]   COUNT,
  output logic                      ALMOST_FULL
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LVL);

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] rd_data;
  logic              full, empty;
  logic              push, pop, thru;
  logic              wr_en, rd_en, mem_we;

  always_comb begin
    full     = (count_q == DEPTH_C);
    empty    = (count_q == '0);
    IN_READY = !full;
`ifdef PIXEL_STREAM_BUFFER_BYPASS_EN
    OUT_VALID = !empty || IN_VALID;
    OUT_D     = empty ? IN_D : rd_data;
    // word handed straight across; never touches storage
    thru      = empty && IN_VALID && OUT_READY;
`else
    OUT_VALID = !empty;
    OUT_D     = rd_data;
    thru      = 1'b0;
`endif
    push   = IN_VALID && IN_READY;
    pop    = OUT_VALID && OUT_READY;
    wr_en  = push && !thru;
    rd_en  = pop && !thru;
    mem_we = wr_en && !FLUSH && !RESET;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign COUNT       = count_q;
  assign ALMOST_FULL = (count_q >= AFULL_C);

  pixel_buf_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (CLK),
    .we    (mem_we),
    .waddr (wr_ptr_q),
    .wdata (IN_D),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

endmodule

// File: tb/tb_pixel_stream_buffer.sv
// Bench for pixel_stream_buffer: vector table plus queue scoreboard.
// Honours PIXEL_STREAM_BUFFER_BYPASS_EN for fall-through expectations.
module tb_pixel_stream_buffer;
  import pixel_buf_pkg::*;

  localparam int DEPTH = 4;

`ifdef PIXEL_STREAM_BUFFER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET, IN_VALID, OUT_READY, FLUSH;
  pixel_t     IN_D, OUT_D;
  logic       IN_READY, OUT_VALID, ALMOST_FULL;
  logic [2:0] COUNT;

  always #5 CLK = ~CLK;

  pixel_stream_buffer #(
    .DATA_W    (16),
    .DEPTH     (DEPTH),
    .AFULL_LVL (DEPTH - 1)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .IN_D        (IN_D),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .OUT_D       (OUT_D),
    .OUT_VALID   (OUT_VALID),
    .OUT_READY   (OUT_READY),
    .FLUSH       (FLUSH),
    .COUNT       (COUNT),
    .ALMOST_FULL (ALMOST_FULL)
  );

  int     tests = 0;
  int     fails = 0;
  pixel_t exp_q[$];

  typedef struct {
    logic       iv;
    pixel_t     d;
    logic       ordy;
    logic [2:0] cnt;
    logic       ir;
    logic       af;
    logic       ov;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // drive one cycle; model checks before the edge, then updates
  task automatic step(input logic iv, input pixel_t d, input logic ordy,
                      input logic fl, input logic rs);
    int     n;
    logic   eov, push, pop, thru;
    pixel_t ehead;
    IN_VALID  = iv;
    IN_D      = d;
    OUT_READY = ordy;
    FLUSH     = fl;
    RESET     = rs;
    @(negedge CLK);
    n     = exp_q.size();
    eov   = (n != 0) || (BYP && iv);
    ehead = (n != 0) ? exp_q[0] : d;
    chk("count", 32'(COUNT), 32'(n));
    chk("in_ready", 32'(IN_READY), 32'(n != DEPTH));
    chk("out_valid", 32'(OUT_VALID), 32'(eov));
    chk("almost_full", 32'(ALMOST_FULL), 32'(n >= DEPTH - 1));
    if (eov && ordy) chk("out_d", 32'(OUT_D), 32'(ehead));
    push = iv && (n != DEPTH);
    pop  = eov && ordy;
    thru = BYP && (n == 0) && iv && ordy;
    if (rs || fl) begin
      exp_q.delete();
    end else if (!thru) begin
      if (pop) void'(exp_q.pop_front());
      if (push) exp_q.push_back(d);
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 16'h1111, 1'b0, 3'd1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 16'h2222, 1'b0, 3'd2, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 16'h3333, 1'b0, 3'd3, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b1, 16'h4444, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{1'b1, 16'h5555, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 16'h0000, 1'b1, 3'd3, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 3'd1, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{1'b0, 16'h0000, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0};

    RESET     = 1'b1;
    IN_VALID  = 1'b0;
    IN_D      = '0;
    OUT_READY = 1'b0;
    FLUSH     = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    #1;
    chk("rst_count", 32'(COUNT), 32'd0);
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_afull", 32'(ALMOST_FULL), 32'd0);

    // fill to full, drop a fifth word, then drain in order
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0, 1'b0);
      chk($sformatf("vec%0d_count", i), 32'(COUNT), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_in_ready", i), 32'(IN_READY), 32'(vecs[i].ir));
      chk($sformatf("vec%0d_afull", i), 32'(ALMOST_FULL), 32'(vecs[i].af));
      chk($sformatf("vec%0d_out_valid", i), 32'(OUT_VALID), 32'(vecs[i].ov));
    end

    // continuous streaming across five pointer wraps
    for (int i = 0; i < 20; i++) begin
      step(1'b1, pixel_t'(i), 1'b1, 1'b0, 1'b0);
      chk($sformatf("stream%0d_count", i), 32'(COUNT), BYP ? 32'd0 : 32'd1);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("stream_drained", 32'(COUNT), 32'd0);

    // flush beats a simultaneous push
    step(1'b1, 16'hA001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hA002, 1'b0, 1'b0, 1'b0);
    chk("pre_flush_count", 32'(COUNT), 32'd2);
    step(1'b1, 16'hABCD, 1'b0, 1'b1, 1'b0);
    IN_VALID = 1'b0;
    FLUSH    = 1'b0;
    #1;
    chk("flush_count", 32'(COUNT), 32'd0);
    chk("flush_out_valid", 32'(OUT_VALID), 32'd0);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    chk("post_flush_head", 32'(OUT_D), 32'hBEEF);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

    // reset mid-stream with push and pop active
    step(1'b1, 16'hC001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hC002, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hC003, 1'b0, 1'b0, 1'b0);
    chk("pre_reset_count", 32'(COUNT), 32'd3);
    step(1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b1);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    #1;
    chk("reset_count", 32'(COUNT), 32'd0);
    chk("reset_in_ready", 32'(IN_READY), 32'd1);
    chk("reset_out_valid", 32'(OUT_VALID), 32'd0);

    // empty buffer, producer and consumer both ready
    IN_VALID  = 1'b1;
    IN_D      = 16'h0F0F;
    OUT_READY = 1'b1;
    #2;
    chk("empty_same_cycle_valid", 32'(OUT_VALID), 32'(BYP));
    if (BYP) chk("bypass_out_d", 32'(OUT_D), 32'h0F0F);
    step(1'b1, 16'h0F0F, 1'b1, 1'b0, 1'b0);
    IN_VALID = 1'b0;
    #1;
    chk("after_empty_count", 32'(COUNT), BYP ? 32'd0 : 32'd1);
    chk("after_empty_valid", 32'(OUT_VALID), BYP ? 32'd0 : 32'd1);
    step(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    chk("final_count", 32'(COUNT), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
